bch_chien_search: RTL and testbench

BCH_CHIEN_SEARCH -- requirements
Module: bch_chien_search

---
 rtl/bch_chien_search.sv | 249 ++++++++++++++++++++++++
 tb/tb_bch_chien_search.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bch_chien_search.sv
// bch_chien_search
//   Chien search over GF(2^M) for a binary BCH decoder. Given the error
//   locator sigma(x) = sigma_0 + sigma_1 x + ... + sigma_T x^T, evaluates
//   sigma(alpha^-j) for j = N-1 down to 0, one position per clock, and flags
//   every position where it is zero. At the end of the sweep it compares the
//   number of roots found against the degree claimed by the locator stage.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   begin a job (taken only while ready=1)
//   sigma      in   locator coefficients, sigma_i at [i*M +: M]
//   err_count  in   locator degree claimed upstream
//   ack_done   in   clears done
//   ready      out  idle and able to accept start
//   err_valid  out  qualifies err / err_first / err_last
//   err        out  current position (j) is in error
//   err_first  out  current position is j = N-1
//   err_last   out  current position is j = 0
//   done       out  job complete, held until ack_done
//   fail       out  word uncorrectable; valid while done=1

// Packed BCH parameter set: P = (M << 8) | T.
`ifndef BCH_SANE
`define BCH_SANE ((4 << 8) | 2)
`endif
`ifndef BCH_M
`define BCH_M(p) (((p) >> 8) & 255)
`endif
`ifndef BCH_T
`define BCH_T(p) ((p) & 255)
`endif
`ifndef BCH_N
`define BCH_N(p) ((1 << `BCH_M(p)) - 1)
`endif
`ifndef BCH_SIGMA_SZ
`define BCH_SIGMA_SZ(p) ((`BCH_T(p) + 1) * `BCH_M(p))
`endif
`ifndef BCH_ERR_SZ
// One bit of headroom so that a claimed degree above T is representable.
`define BCH_ERR_SZ(p) ($clog2(`BCH_T(p) + 1) + 1)
`endif

module bch_chien_search #(
    parameter int unsigned P = `BCH_SANE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [`BCH_SIGMA_SZ(P)-1:0]   sigma,
    input  logic [`BCH_ERR_SZ(P)-1:0]     err_count,
    input  logic                          ack_done,
    output logic                          ready,
    output logic                          err_valid,
    output logic                          err,
    output logic                          err_first,
    output logic                          err_last,
    output logic                          done,
    output logic                          fail
);

    localparam int unsigned M  = `BCH_M(P);
    localparam int unsigned T  = `BCH_T(P);
    localparam int unsigned N  = `BCH_N(P);
    localparam int unsigned EW = `BCH_ERR_SZ(P);

    // Low-order coefficients of a primitive polynomial x^M + ... for each M.
    function automatic logic [31:0] prim_low(input int unsigned m);
        case (m)
            2:       return 32'h3;    // x^2+x+1
            3:       return 32'h3;    // x^3+x+1
            4:       return 32'h3;    // x^4+x+1
            5:       return 32'h5;    // x^5+x^2+1
            6:       return 32'h3;    // x^6+x+1
            7:       return 32'h3;    // x^7+x+1
            8:       return 32'h1d;   // x^8+x^4+x^3+x^2+1
            9:       return 32'h11;   // x^9+x^4+1
            10:      return 32'h9;    // x^10+x^3+1
            11:      return 32'h5;    // x^11+x^2+1
            12:      return 32'h53;   // x^12+x^6+x^4+x+1
            13:      return 32'h1b;   // x^13+x^4+x^3+x+1
            14:      return 32'h2b;   // x^14+x^5+x^3+x+1
            15:      return 32'h3;    // x^15+x+1
            16:      return 32'h2d;   // x^16+x^5+x^3+x^2+1
            default: return 32'h3;
        endcase
    endfunction

    localparam logic [31:0]   POLY_FULL = prim_low(M);
    localparam logic [M-1:0]  POLY      = POLY_FULL[M-1:0];
    localparam logic [M-1:0]  LAST_POS  = M'(N - 1);
    localparam logic [EW-1:0] T_CAP     = EW'(T);
    localparam logic [EW-1:0] T_SAT     = EW'(T + 1);

    // Multiply by alpha: shift, then fold x^M back through the polynomial.
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
    endfunction

    // Multiply by alpha^n for a constant n in 0..T (loop bound kept static).
    function automatic logic [M-1:0] gf_mul_apow(input logic [M-1:0] a, input int unsigned n);
        logic [M-1:0] v;
        v = a;
        for (int unsigned k = 0; k < T + 1; k++) begin
            if (k < n) begin
                v = gf_xtime(v);
            end
        end
        return v;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [M-1:0]    r_sigma [T+1];
    logic [M-1:0]    w_sigma_d [T+1];
    logic [M-1:0]    r_term [T+1];
    logic [M-1:0]    w_term_d [T+1];
    logic [EW-1:0]   r_err_count;
    logic [EW-1:0]   w_err_count_d;
    logic [EW-1:0]   r_found;
    logic [EW-1:0]   w_found_d;
    logic [EW-1:0]   w_found_inc;
    logic [M-1:0]    r_pos;
    logic [M-1:0]    w_pos_d;
    logic            r_done;
    logic            w_done_d;
    logic            r_fail;
    logic            w_fail_d;
    logic [M-1:0]    w_sum;
    logic            w_hit;
    logic            w_run;
    logic            w_ready;

    // sigma evaluated at the current position is the XOR of all terms.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < T + 1; i++) begin
            w_sum = w_sum ^ r_term[i];
        end
    end

    assign w_hit   = (w_sum == '0);
    assign w_run   = (r_state == StRun);
    assign w_ready = (r_state == StIdle) && (!r_done || ack_done);

    // Root counter saturates at T+1: any count above T is already a failure.
    always_comb begin
        w_found_inc = r_found;
        if (w_run && w_hit && (r_found != T_SAT)) begin
            w_found_inc = r_found + EW'(1);
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_err_count_d = r_err_count;
        w_found_d     = r_found;
        w_pos_d       = r_pos;
        w_done_d      = r_done;
        w_fail_d      = r_fail;
        for (int i = 0; i < T + 1; i++) begin
            w_sigma_d[i] = r_sigma[i];
            w_term_d[i]  = r_term[i];
        end

        if (ack_done) begin
            w_done_d = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                if (start && w_ready) begin
                    for (int i = 0; i < T + 1; i++) begin
                        w_sigma_d[i] = sigma[i*M +: M];
                    end
                    w_err_count_d = err_count;
                    w_found_d     = '0;
                    w_state_d     = StInit;
                end
            end
            StInit: begin
                // alpha^-(N-1) == alpha^1, so term_i starts at sigma_i * alpha^i;
                // the same constant multiplier then steps one position per cycle.
                for (int i = 0; i < T + 1; i++) begin
                    w_term_d[i] = gf_mul_apow(r_sigma[i], i);
                end
                w_pos_d   = LAST_POS;
                w_state_d = StRun;
            end
            StRun: begin
                for (int i = 0; i < T + 1; i++) begin
                    w_term_d[i] = gf_mul_apow(r_term[i], i);
                end
                w_found_d = w_found_inc;
                if (r_pos == '0) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                    w_fail_d  = (w_found_inc != r_err_count) || (r_err_count > T_CAP);
                end else begin
                    w_pos_d = r_pos - M'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_err_count <= '0;
            r_found     <= '0;
            r_pos       <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            for (int i = 0; i < T + 1; i++) begin
                r_sigma[i] <= '0;
                r_term[i]  <= '0;
            end
        end else begin
            r_state     <= w_state_d;
            r_err_count <= w_err_count_d;
            r_found     <= w_found_d;
            r_pos       <= w_pos_d;
            r_done      <= w_done_d;
            r_fail      <= w_fail_d;
            for (int i = 0; i < T + 1; i++) begin
                r_sigma[i] <= w_sigma_d[i];
                r_term[i]  <= w_term_d[i];
            end
        end
    end

    assign ready     = w_ready;
    assign err_valid = w_run;
    assign err       = w_run && w_hit;
    assign err_first = w_run && (r_pos == LAST_POS);
    assign err_last  = w_run && (r_pos == '0);
    assign done      = r_done;
    assign fail      = r_fail;

endmodule

// File: tb/tb_bch_chien_search.sv
// tb_bch_chien_search
//   Directed bench for bch_chien_search with the default parameter set
//   (M=4, T=2, N=15, x^4+x+1). GF(16): a^3=8, a^5=6, a^10=7.
//   Position j is reported on the (15-j)-th valid cycle.

module tb_bch_chien_search;

    localparam int N = 15;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        ack_done  = 1'b0;
    logic [11:0] sigma     = '0;
    logic [2:0]  err_count = '0;
    logic        ready;
    logic        err_valid;
    logic        err;
    logic        err_first;
    logic        err_last;
    logic        done;
    logic        fail;

    int vectors     = 0;
    int miscompares = 0;

    // Results collected by run_job.
    logic [14:0] job_mask;
    int          job_nvalid;
    int          job_first_idx;
    int          job_last_idx;
    int          job_first_cnt;
    int          job_last_cnt;
    int          job_first_edge;
    int          job_done_edge;
    int          job_stray;
    logic        job_init_ok;

    always #5 clk = ~clk;

    bch_chien_search dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sigma     (sigma),
        .err_count (err_count),
        .ack_done  (ack_done),
        .ready     (ready),
        .err_valid (err_valid),
        .err       (err),
        .err_first (err_first),
        .err_last  (err_last),
        .done      (done),
        .fail      (fail)
    );

    // Drives one job and records what the DUT streams. Called between edges;
    // returns just after the negedge on which done is seen (or the budget runs out).
    // Inputs are scrambled right after capture so stale-capture bugs show up.
    task automatic run_job(input logic [11:0] s, input logic [2:0] ec,
                           input bit with_ack, input bit poke);
        job_mask = '0; job_nvalid = 0; job_first_idx = 0; job_last_idx = 0;
        job_first_cnt = 0; job_last_cnt = 0; job_first_edge = 0;
        job_done_edge = 0; job_stray = 0;
        sigma = s; err_count = ec; start = 1'b1; ack_done = with_ack;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; ack_done = 1'b0; sigma = ~s; err_count = 3'd5;
        job_init_ok = !ready && !err_valid && !done;
        for (int e = 1; e <= 40; e++) begin
            if (poke) start = (e >= 3 && e <= 6);
            @(negedge clk);
            if (err_valid) begin
                job_nvalid++;
                if (job_nvalid == 1) job_first_edge = e;
                if (job_nvalid <= N) job_mask[N - job_nvalid] = err;
                if (err_first) begin job_first_cnt++; job_first_idx = job_nvalid; end
                if (err_last)  begin job_last_cnt++;  job_last_idx  = job_nvalid; end
            end else if (err || err_first || err_last) begin
                job_stray++;
            end
            if (done) begin
                job_done_edge = e;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack_done = 1'b1;
        @(negedge clk);
        ack_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", err_valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail: got %b want 0", fail); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
        vectors++; if ({err, err_first, err_last} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {err, err_first, err_last}); end
    endtask

    // sigma = 1 + a^3 x: single root at j=3 (12th valid cycle).
    task automatic test_single_error();
        run_job(12'h081, 3'd1, 1'b0, 1'b0);
        vectors++; if (job_init_ok !== 1'b1) begin miscompares++; $display("FAIL single_init: got %b want 1", job_init_ok); end
        vectors++; if (job_mask !== 15'h0008) begin miscompares++; $display("FAIL single_mask: got %h want 0008", job_mask); end
        vectors++; if (job_nvalid != 15) begin miscompares++; $display("FAIL single_nvalid: got %0d want 15", job_nvalid); end
        vectors++; if (job_first_edge != 1) begin miscompares++; $display("FAIL single_first_edge: got %0d want 1", job_first_edge); end
        vectors++; if (job_done_edge != 16) begin miscompares++; $display("FAIL single_done_edge: got %0d want 16", job_done_edge); end
        vectors++; if (job_first_idx != 1 || job_first_cnt != 1) begin miscompares++; $display("FAIL single_first: got idx %0d cnt %0d want 1 1", job_first_idx, job_first_cnt); end
        vectors++; if (job_last_idx != 15 || job_last_cnt != 1) begin miscompares++; $display("FAIL single_last: got idx %0d cnt %0d want 15 1", job_last_idx, job_last_cnt); end
        vectors++; if (job_stray != 0) begin miscompares++; $display("FAIL single_stray: got %0d want 0", job_stray); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL single_fail: got %b want 0", fail); end
    endtask

    // sigma = 1 + a^10 x + a^5 x^2 started together with ack_done of the previous job.
    task automatic test_ack_with_start();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ackstart_pre_done: got %b want 1", done); end
        run_job(12'h671, 3'd2, 1'b1, 1'b0);
        vectors++; if (job_init_ok !== 1'b1) begin miscompares++; $display("FAIL ackstart_init: got %b want 1", job_init_ok); end
        vectors++; if (job_mask !== 15'h0021) begin miscompares++; $display("FAIL two_mask: got %h want 0021", job_mask); end
        vectors++; if (job_last_idx != 15) begin miscompares++; $display("FAIL two_last_idx: got %0d want 15", job_last_idx); end
        vectors++; if (job_done_edge != 16) begin miscompares++; $display("FAIL two_done_edge: got %0d want 16", job_done_edge); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL two_fail: got %b want 0", fail); end
        do_ack();
    endtask

    task automatic test_no_errors();
        run_job(12'h001, 3'd0, 1'b0, 1'b0);
        vectors++; if (job_mask !== 15'h0000) begin miscompares++; $display("FAIL none_mask: got %h want 0000", job_mask); end
        vectors++; if (job_nvalid != 15) begin miscompares++; $display("FAIL none_nvalid: got %0d want 15", job_nvalid); end
        vectors++; if (job_first_idx != 1 || job_last_idx != 15) begin miscompares++; $display("FAIL none_marks: got %0d %0d want 1 15", job_first_idx, job_last_idx); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL none_fail: got %b want 0", fail); end
        do_ack();
    endtask

    // One root found but two claimed: fail, and done held until acknowledged.
    task automatic test_fail_mismatch();
        run_job(12'h081, 3'd2, 1'b0, 1'b0);
        vectors++; if (job_mask !== 15'h0008) begin miscompares++; $display("FAIL mism_mask: got %h want 0008", job_mask); end
        vectors++; if (fail !== 1'b1) begin miscompares++; $display("FAIL mism_fail: got %b want 1", fail); end
        repeat (3) @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mism_done_held: got %b want 1", done); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL mism_ready_held: got %b want 0", ready); end
        ack_done = 1'b1;
        #1;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL mism_ready_ack: got %b want 1", ready); end
        @(negedge clk);
        ack_done = 1'b0;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mism_done_clear: got %b want 0", done); end
        vectors++; if (fail !== 1'b1) begin miscompares++; $display("FAIL mism_fail_hold: got %b want 1", fail); end
    endtask

    // sigma = 0 hits everywhere; count saturates at 3 == claim, yet claim > T fails.
    task automatic test_over_t();
        run_job(12'h000, 3'd3, 1'b0, 1'b0);
        vectors++; if (job_mask !== 15'h7fff) begin miscompares++; $display("FAIL overt_mask: got %h want 7fff", job_mask); end
        vectors++; if (fail !== 1'b1) begin miscompares++; $display("FAIL overt_fail: got %b want 1", fail); end
        do_ack();
    endtask

    task automatic test_busy_start();
        run_job(12'h081, 3'd1, 1'b0, 1'b1);
        vectors++; if (job_mask !== 15'h0008) begin miscompares++; $display("FAIL busy_mask: got %h want 0008", job_mask); end
        vectors++; if (job_nvalid != 15 || job_done_edge != 16) begin miscompares++; $display("FAIL busy_len: got %0d %0d want 15 16", job_nvalid, job_done_edge); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL busy_fail: got %b want 0", fail); end
        @(negedge clk);
        vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL busy_after: got %b want 0", err_valid); end
        do_ack();
    endtask

    task automatic test_reset_mid_run();
        sigma = 12'h081; err_count = 3'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if (err_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_running: got %b want 1", err_valid); end
        reset = 1'b1; start = 1'b1; ack_done = 1'b1;
        @(negedge clk);
        vectors++; if ({err_valid, err, done} !== 3'b000) begin miscompares++; $display("FAIL midrst_out: got %b want 000", {err_valid, err, done}); end
        reset = 1'b0; start = 1'b0; ack_done = 1'b0;
        @(negedge clk);
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", ready); end
        vectors++; if ({err_valid, done} !== 2'b00) begin miscompares++; $display("FAIL midrst_idle: got %b want 00", {err_valid, done}); end
        run_job(12'h671, 3'd2, 1'b0, 1'b0);
        vectors++; if (job_mask !== 15'h0021) begin miscompares++; $display("FAIL midrst_rerun_mask: got %h want 0021", job_mask); end
        vectors++; if (job_done_edge != 16 || fail !== 1'b0) begin miscompares++; $display("FAIL midrst_rerun_end: got %0d %b want 16 0", job_done_edge, fail); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_single_error();
        test_ack_with_start();
        test_no_errors();
        test_fail_mismatch();
        test_over_t();
        test_busy_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
